// File: rtl/ctrlu_mc.sv
// Multi-cycle RV32I(+M) control unit: fetch/decode/execute sequencing, data-memory
// handshake with timeout, optional MDU hand-off and trap/halt handling.
module ctrlu_mc #(
  parameter int unsigned M_EXT       = 0,
  parameter int unsigned HALT_ON_ILL = 1,
  parameter int unsigned TMO_CYC     = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_instr,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  input  logic        i_imem_ack,
  input  logic        i_dmem_ack,
  input  logic        i_mdu_done,
  output logic        o_imem_req,
  output logic        o_ir_en,
  output logic        o_pc_sel,
  output logic        o_pc_en,
  output logic        o_rd_wren,
  output logic        o_insn_vld,
  output logic        o_br_un,
  output logic        o_opa_sel,
  output logic        o_opb_sel,
  output logic [3:0]  o_alu_op,
  output logic        o_mem_req,
  output logic        o_mem_wren,
  output logic        o_mem_un,
  output logic [3:0]  o_mask,
  output logic [1:0]  o_wb_sel,
  output logic        o_mdu_start,
  output logic [2:0]  o_mdu_op,
  output logic        o_mdu_sel,
  output logic        o_illegal,
  output logic        o_bus_err,
  output logic        o_halt
);

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StMem, StMdu, StTrap, StHalt
  } state_e;

  localparam logic [7:0] TmoLim = 8'(TMO_CYC);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       bus_err_q, bus_err_d;
  logic       mdu_first_q, mdu_first_d;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_br, is_load, is_store, is_opimm, is_op;
  logic       is_mtype, legal, br_taken, alt_op, expired;
  logic [3:0] alu_dec;
  logic       unused_instr;

  assign opcode       = i_instr[6:0];
  assign funct3       = i_instr[14:12];
  assign funct7       = i_instr[31:25];
  assign unused_instr = ^{i_instr[24:15], i_instr[11:7]};

  assign is_lui   = opcode == 7'b0110111;
  assign is_auipc = opcode == 7'b0010111;
  assign is_jal   = opcode == 7'b1101111;
  assign is_jalr  = opcode == 7'b1100111;
  assign is_br    = opcode == 7'b1100011;
  assign is_load  = opcode == 7'b0000011;
  assign is_store = opcode == 7'b0100011;
  assign is_opimm = opcode == 7'b0010011;
  assign is_op    = opcode == 7'b0110011;
  assign is_mtype = is_op && (funct7 == 7'b0000001);

  always_comb begin
    legal = 1'b0;
    if (is_lui || is_auipc || is_jal) begin
      legal = 1'b1;
    end else if (is_jalr) begin
      legal = funct3 == 3'b000;
    end else if (is_br) begin
      legal = funct3[2:1] != 2'b01;
    end else if (is_load) begin
      legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end else if (is_store) begin
      legal = funct3 inside {3'b000, 3'b001, 3'b010};
    end else if (is_opimm) begin
      if (funct3 == 3'b001)      legal = funct7 == 7'b0000000;
      else if (funct3 == 3'b101) legal = funct7 inside {7'b0000000, 7'b0100000};
      else                       legal = 1'b1;
    end else if (is_op) begin
      legal = (funct7 == 7'b0000000) ||
              ((funct7 == 7'b0100000) && (funct3 inside {3'b000, 3'b101})) ||
              (is_mtype && (M_EXT != 0));
    end
  end

  // funct7[5] selects SUB (register form only) and SRA/SRAI.
  assign alt_op  = funct7[5] && ((is_op && funct3 == 3'b000) ||
                                 ((is_op || is_opimm) && funct3 == 3'b101));
  assign alu_dec = (is_op || is_opimm) ? {alt_op, funct3} : 4'b0000;
  assign expired = (wait_q + 8'd1) == TmoLim;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:         br_taken = i_br_equal;
      3'b001:         br_taken = !i_br_equal;
      3'b100, 3'b110: br_taken = i_br_less;
      3'b101, 3'b111: br_taken = !i_br_less;
      default:        br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    bus_err_d   = bus_err_q;
    mdu_first_d = 1'b0;
    o_imem_req  = 1'b0;
    o_ir_en     = 1'b0;
    o_pc_sel    = 1'b0;
    o_pc_en     = 1'b0;
    o_rd_wren   = 1'b0;
    o_insn_vld  = 1'b0;
    o_br_un     = 1'b0;
    o_opa_sel   = 1'b0;
    o_opb_sel   = 1'b0;
    o_alu_op    = 4'b0000;
    o_mem_req   = 1'b0;
    o_mem_wren  = 1'b0;
    o_mem_un    = 1'b0;
    o_mask      = 4'b0000;
    o_wb_sel    = 2'b00;
    o_mdu_start = 1'b0;
    o_mdu_op    = 3'b000;
    o_mdu_sel   = 1'b0;
    o_illegal   = 1'b0;
    o_bus_err   = 1'b0;
    o_halt      = 1'b0;

    if (state_q inside {StDecode, StExec, StMem, StMdu}) begin
      o_opa_sel = is_auipc || is_jal || is_br;
      o_opb_sel = !is_op;
      o_alu_op  = alu_dec;
      o_br_un   = is_br && (funct3[2:1] == 2'b11);
      o_pc_sel  = is_jal || is_jalr;
      if (is_load)                o_wb_sel = 2'b01;
      else if (is_lui)            o_wb_sel = 2'b10;
      else if (is_jal || is_jalr) o_wb_sel = 2'b11;
    end

    unique case (state_q)
      StFetch: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          o_ir_en = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (!legal) begin
          state_d   = StTrap;
          bus_err_d = 1'b0;
        end else if (is_load || is_store) begin
          state_d = StMem;
          wait_d  = 8'd0;
        end else if (is_mtype) begin
          state_d     = StMdu;
          mdu_first_d = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        o_pc_en    = 1'b1;
        o_insn_vld = 1'b1;
        o_rd_wren  = !is_br;
        if (is_br) o_pc_sel = br_taken;
        state_d = StFetch;
      end
      StMem: begin
        o_mem_req  = 1'b1;
        o_mem_wren = is_store;
        o_mem_un   = is_load && funct3[2];
        case (funct3[1:0])
          2'b00:   o_mask = 4'b0001;
          2'b01:   o_mask = 4'b0011;
          default: o_mask = 4'b1111;
        endcase
        // An ack arriving in the expiry cycle still retires normally.
        if (i_dmem_ack) begin
          o_pc_en    = 1'b1;
          o_insn_vld = 1'b1;
          o_rd_wren  = is_load;
          state_d    = StFetch;
        end else if (expired) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StMdu: begin
        o_mdu_start = mdu_first_q;
        o_mdu_op    = funct3;
        if (i_mdu_done) begin
          o_rd_wren  = 1'b1;
          o_pc_en    = 1'b1;
          o_insn_vld = 1'b1;
          o_mdu_sel  = 1'b1;
          state_d    = StFetch;
        end
      end
      StTrap: begin
        o_illegal = !bus_err_q;
        o_bus_err = bus_err_q;
        if (HALT_ON_ILL != 0) begin
          state_d = StHalt;
        end else begin
          o_pc_en = 1'b1;
          state_d = StFetch;
        end
      end
      StHalt: begin
        o_halt = 1'b1;
      end
      default: state_d = StFetch;
    endcase

    if (i_reset) begin
      o_imem_req  = 1'b0;
      o_ir_en     = 1'b0;
      o_pc_sel    = 1'b0;
      o_pc_en     = 1'b0;
      o_rd_wren   = 1'b0;
      o_insn_vld  = 1'b0;
      o_br_un     = 1'b0;
      o_opa_sel   = 1'b0;
      o_opb_sel   = 1'b0;
      o_alu_op    = 4'b0000;
      o_mem_req   = 1'b0;
      o_mem_wren  = 1'b0;
      o_mem_un    = 1'b0;
      o_mask      = 4'b0000;
      o_wb_sel    = 2'b00;
      o_mdu_start = 1'b0;
      o_mdu_op    = 3'b000;
      o_mdu_sel   = 1'b0;
      o_illegal   = 1'b0;
      o_bus_err   = 1'b0;
      o_halt      = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= StFetch;
      wait_q      <= 8'd0;
      bus_err_q   <= 1'b0;
      mdu_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      bus_err_q   <= bus_err_d;
      mdu_first_q <= mdu_first_d;
    end
  end

endmodule

// File: tb/tb_ctrlu_mc.sv
// Directed bench for ctrlu_mc: default build (a) and M_EXT=1/HALT_ON_ILL=0 build (b)
// driven in lockstep from shared inputs.
module tb_ctrlu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        br_less, br_equal, imem_ack, dmem_ack, mdu_done;

  logic        imem_req_a, ir_en_a, pc_sel_a, pc_en_a, rd_wren_a, insn_vld_a, br_un_a;
  logic        opa_sel_a, opb_sel_a, mem_req_a, mem_wren_a, mem_un_a, mdu_start_a, mdu_sel_a;
  logic        illegal_a, bus_err_a, halt_a;
  logic [3:0]  alu_op_a, mask_a;
  logic [1:0]  wb_sel_a;
  logic [2:0]  mdu_op_a;

  logic        imem_req_b, ir_en_b, pc_sel_b, pc_en_b, rd_wren_b, insn_vld_b, br_un_b;
  logic        opa_sel_b, opb_sel_b, mem_req_b, mem_wren_b, mem_un_b, mdu_start_b, mdu_sel_b;
  logic        illegal_b, bus_err_b, halt_b;
  logic [3:0]  alu_op_b, mask_b;
  logic [1:0]  wb_sel_b;
  logic [2:0]  mdu_op_b;

  logic [29:0] all_a, all_b;
  int          checks = 0;
  int          failures = 0;
  int          n;

  localparam logic [31:0] InsLw = 32'h00012083;
  localparam logic [31:0] InsSw = 32'h00312023;

  always #5 clk = ~clk;

  assign all_a = {imem_req_a, ir_en_a, pc_sel_a, pc_en_a, rd_wren_a, insn_vld_a, br_un_a,
                  opa_sel_a, opb_sel_a, alu_op_a, mem_req_a, mem_wren_a, mem_un_a, mask_a,
                  wb_sel_a, mdu_start_a, mdu_op_a, mdu_sel_a, illegal_a, bus_err_a, halt_a};
  assign all_b = {imem_req_b, ir_en_b, pc_sel_b, pc_en_b, rd_wren_b, insn_vld_b, br_un_b,
                  opa_sel_b, opb_sel_b, alu_op_b, mem_req_b, mem_wren_b, mem_un_b, mask_b,
                  wb_sel_b, mdu_start_b, mdu_op_b, mdu_sel_b, illegal_b, bus_err_b, halt_b};

  ctrlu_mc dut_a (
    .i_clk(clk), .i_reset(rst), .i_instr(instr), .i_br_less(br_less), .i_br_equal(br_equal),
    .i_imem_ack(imem_ack), .i_dmem_ack(dmem_ack), .i_mdu_done(mdu_done),
    .o_imem_req(imem_req_a), .o_ir_en(ir_en_a), .o_pc_sel(pc_sel_a), .o_pc_en(pc_en_a),
    .o_rd_wren(rd_wren_a), .o_insn_vld(insn_vld_a), .o_br_un(br_un_a),
    .o_opa_sel(opa_sel_a), .o_opb_sel(opb_sel_a), .o_alu_op(alu_op_a),
    .o_mem_req(mem_req_a), .o_mem_wren(mem_wren_a), .o_mem_un(mem_un_a), .o_mask(mask_a),
    .o_wb_sel(wb_sel_a), .o_mdu_start(mdu_start_a), .o_mdu_op(mdu_op_a),
    .o_mdu_sel(mdu_sel_a), .o_illegal(illegal_a), .o_bus_err(bus_err_a), .o_halt(halt_a)
  );

  ctrlu_mc #(.M_EXT(1), .HALT_ON_ILL(0), .TMO_CYC(16)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_instr(instr), .i_br_less(br_less), .i_br_equal(br_equal),
    .i_imem_ack(imem_ack), .i_dmem_ack(dmem_ack), .i_mdu_done(mdu_done),
    .o_imem_req(imem_req_b), .o_ir_en(ir_en_b), .o_pc_sel(pc_sel_b), .o_pc_en(pc_en_b),
    .o_rd_wren(rd_wren_b), .o_insn_vld(insn_vld_b), .o_br_un(br_un_b),
    .o_opa_sel(opa_sel_b), .o_opb_sel(opb_sel_b), .o_alu_op(alu_op_b),
    .o_mem_req(mem_req_b), .o_mem_wren(mem_wren_b), .o_mem_un(mem_un_b), .o_mask(mask_b),
    .o_wb_sel(wb_sel_b), .o_mdu_start(mdu_start_b), .o_mdu_op(mdu_op_b),
    .o_mdu_sel(mdu_sel_b), .o_illegal(illegal_b), .o_bus_err(bus_err_b), .o_halt(halt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; mdu_done = 1'b0;
    #1;
    check_eq("rst_outs_a", 32'(all_a), 32'd0);
    check_eq("rst_outs_b", 32'(all_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rel_imem_req", 32'(imem_req_a), 32'd1);
  endtask

  // Fetch with same-cycle ack; returns sampled inside the DECODE cycle.
  task automatic fetch(input logic [31:0] ins);
    @(negedge clk);
    instr = ins; imem_ack = 1'b1;
    #1;
    check_eq("fetch_req_ir", 32'({imem_req_a, ir_en_a}), 32'd3);
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    check_eq("dec_strobes", 32'({pc_en_a, rd_wren_a, insn_vld_a, imem_req_a}), 32'd0);
  endtask

  initial begin
    rst = 1'b1; instr = 32'd0; br_less = 1'b0; br_equal = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; mdu_done = 1'b0;
    do_reset();

    fetch(32'h003100B3);  // add x1,x2,x3
    @(negedge clk); #1;
    check_eq("add_strobes", 32'({rd_wren_a, pc_en_a, insn_vld_a}), 32'd7);
    check_eq("add_alu", 32'(alu_op_a), 32'h0);
    check_eq("add_opb", 32'(opb_sel_a), 32'd0);

    fetch(32'h403100B3);  // sub
    @(negedge clk); #1;
    check_eq("sub_alu", 32'(alu_op_a), 32'h8);

    fetch(32'h40315093);  // srai x1,x2,3
    @(negedge clk); #1;
    check_eq("srai_alu_opb", 32'({alu_op_a, opb_sel_a}), 32'h1B);

    fetch(32'h123450B7);  // lui
    @(negedge clk); #1;
    check_eq("lui_wb_wren", 32'({wb_sel_a, rd_wren_a}), 32'h5);

    fetch(32'h000000EF);  // jal x1,0
    @(negedge clk); #1;
    check_eq("jal_sel", 32'({pc_sel_a, wb_sel_a, opa_sel_a, rd_wren_a}), 32'h1F);

    fetch(32'h00311463);  // bne
    @(negedge clk); br_equal = 1'b0; br_less = 1'b0; #1;
    check_eq("bne_taken", 32'({pc_sel_a, rd_wren_a, pc_en_a, insn_vld_a}), 32'hB);

    fetch(32'h00317463);  // bgeu
    @(negedge clk); br_less = 1'b1; #1;
    check_eq("bgeu_not_taken", 32'({pc_sel_a, br_un_a}), 32'h1);
    br_less = 1'b0;

    fetch(InsLw);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); dmem_ack = (k == 3); #1;
      if (mem_req_a) n++;
      check_eq("lw_rd_wren", 32'(rd_wren_a), 32'(k == 3));
      if (k == 0) check_eq("lw_mask_wb", 32'({mask_a, wb_sel_a}), 32'h3D);
    end
    @(negedge clk); dmem_ack = 1'b0; #1;
    check_eq("lw_req_cycles", 32'(n), 32'd4);
    check_eq("lw_back_fetch", 32'({imem_req_a, mem_req_a}), 32'h2);

    fetch(InsSw);  // ack lands in the expiry cycle
    n = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); dmem_ack = (k == 15); #1;
      if (mem_req_a) n++;
    end
    check_eq("sw_late_ret", 32'({pc_en_a, insn_vld_a, rd_wren_a, bus_err_a}), 32'hC);
    @(negedge clk); dmem_ack = 1'b0; #1;
    check_eq("sw_late_cycles", 32'(n), 32'd16);
    check_eq("sw_late_fetch", 32'({imem_req_a, bus_err_a}), 32'h2);

    fetch(InsSw);  // no ack: timeout
    n = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #1;
      if (mem_req_a && mem_wren_a) n++;
      if (k == 0) check_eq("sw_mask", 32'(mask_a), 32'hF);
    end
    @(negedge clk); #1;
    check_eq("sw_tmo_cycles", 32'(n), 32'd16);
    check_eq("sw_tmo_trap_a", 32'({bus_err_a, illegal_a, rd_wren_a, mem_req_a}), 32'h8);
    check_eq("sw_tmo_trap_b", 32'({bus_err_b, pc_en_b, insn_vld_b, pc_sel_b}), 32'hC);
    @(negedge clk); #1;
    check_eq("sw_tmo_halt_a", 32'(halt_a), 32'd1);
    check_eq("sw_tmo_skip_b", 32'(imem_req_b), 32'd1);
    @(negedge clk); #1;
    check_eq("halt_hold_a", 32'({halt_a, imem_req_a, pc_en_a}), 32'h4);
    do_reset();

    fetch(32'h02310033);  // mul
    @(negedge clk); #1;
    check_eq("mul_illegal_a", 32'(illegal_a), 32'd1);
    check_eq("mul_start_b", 32'({mdu_start_b, mdu_op_b}), 32'h8);
    @(negedge clk); #1;
    check_eq("mul_halt_a", 32'(halt_a), 32'd1);
    check_eq("mul_wait_b", 32'({mdu_start_b, rd_wren_b, pc_en_b}), 32'd0);
    @(negedge clk); mdu_done = 1'b1; #1;
    check_eq("mul_ret_b", 32'({rd_wren_b, pc_en_b, insn_vld_b, mdu_sel_b}), 32'hF);
    @(negedge clk); mdu_done = 1'b0; #1;
    check_eq("mul_fetch_b", 32'(imem_req_b), 32'd1);
    do_reset();

    fetch(32'h023140B3);  // div, done in the start cycle
    @(negedge clk); mdu_done = 1'b1; #1;
    check_eq("div_start_b", 32'({mdu_start_b, mdu_op_b}), 32'hC);
    check_eq("div_ret_b", 32'({rd_wren_b, pc_en_b, insn_vld_b, mdu_sel_b}), 32'hF);
    check_eq("div_illegal_a", 32'(illegal_a), 32'd1);
    @(negedge clk); mdu_done = 1'b0; #1;
    check_eq("div_fetch_b", 32'({imem_req_b, mdu_start_b}), 32'h2);
    do_reset();

    fetch(32'h00000000);  // illegal opcode, skip on b
    @(negedge clk); #1;
    check_eq("ill_trap_b",
             32'({illegal_b, pc_en_b, pc_sel_b, insn_vld_b, rd_wren_b}), 32'h18);
    @(negedge clk); #1;
    check_eq("ill_skip_b", 32'({imem_req_b, halt_b}), 32'h2);
    do_reset();

    fetch(InsLw);
    @(negedge clk); #1;
    check_eq("mid_mem_req", 32'(mem_req_a), 32'd1);
    @(negedge clk); #1;
    @(negedge clk); rst = 1'b1; #1;
    check_eq("mid_mem_rst", 32'(all_a), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    check_eq("mid_mem_rel", 32'({imem_req_a, mem_req_a}), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
